data_mem_responder: RTL and testbench

//  Per-lane data-memory responder: target side of the SIMD lane LSU request interface.

---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 90 +++++++++
 tb/tb_data_mem_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Lane-side request/response bundle between the SIMD LSUs and the data-memory responder.
// Handshake: a lane holds read/write valid (level) until it sees a one-cycle ack, then drops valid >=1 cycle.
interface data_mem_responder_if #(
  parameter int DATA_WIDTH          = 64,
  parameter int DATA_REG_ADDR_WIDTH = 7,
  parameter int LANE_WIDTH          = 16
);
  logic [LANE_WIDTH-1:0]                          mem_read_valid;
  logic [LANE_WIDTH-1:0]                          mem_write_valid;
  logic [LANE_WIDTH-1:0][DATA_REG_ADDR_WIDTH-1:0] mem_addr;
  logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0]          mem_write_data;
  logic [LANE_WIDTH-1:0]                          data_mem_ready_ack;
  logic [LANE_WIDTH-1:0]                          data_mem_write_ack;
  logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0]          mem_read_data;

  modport master (
    output mem_read_valid, mem_write_valid, mem_addr, mem_write_data,
    input  data_mem_ready_ack, data_mem_write_ack, mem_read_data
  );

  modport slave (
    input  mem_read_valid, mem_write_valid, mem_addr, mem_write_data,
    output data_mem_ready_ack, data_mem_write_ack, mem_read_data
  );
endinterface

// File: rtl/data_mem_responder.sv
// Per-lane data-memory responder: round-robin grants up to NUM_PORTS lanes per cycle
// onto an internal word array, with registered one-cycle acks and a host preload port.
module data_mem_responder #(
  parameter int DATA_WIDTH          = 64,
  parameter int DATA_REG_ADDR_WIDTH = 7,
  parameter int LANE_WIDTH          = 16,
  parameter int NUM_PORTS           = 4,
  localparam int DEPTH = 2 ** DATA_REG_ADDR_WIDTH,
  localparam int PW    = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  data_mem_responder_if.slave            bus,
  input  logic                           host_write_en,
  input  logic [DATA_REG_ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]          host_data,
  output logic [PW-1:0]                  o_rr_ptr
);

  logic [DATA_WIDTH-1:0]                 r_mem [DEPTH];
  logic [LANE_WIDTH-1:0]                 r_served;
  logic [PW-1:0]                         r_rr_ptr;
  logic [LANE_WIDTH-1:0]                 r_ready_ack;
  logic [LANE_WIDTH-1:0]                 r_write_ack;
  logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0] r_read_data;

  logic [LANE_WIDTH-1:0] w_active;
  logic [LANE_WIDTH-1:0] w_pending;
  logic [LANE_WIDTH-1:0] w_grant;
  logic [PW-1:0]         w_last;
  logic                  w_any;

  assign w_active  = bus.mem_read_valid | bus.mem_write_valid;
  assign w_pending = w_active & ~r_served;

  // Walk lanes cyclically from the pointer, granting the first NUM_PORTS pending ones.
  always_comb begin
    int cnt;
    int idx;
    cnt     = 0;
    idx     = 0;
    w_grant = '0;
    w_last  = r_rr_ptr;
    w_any   = 1'b0;
    for (int k = 0; k < LANE_WIDTH; k++) begin
      idx = (int'(r_rr_ptr) + k) % LANE_WIDTH;
      if (w_pending[idx] && (cnt < NUM_PORTS)) begin
        w_grant[idx] = 1'b1;
        w_last       = PW'(idx);
        w_any        = 1'b1;
        cnt          = cnt + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_served    <= '0;
      r_rr_ptr    <= '0;
      r_ready_ack <= '0;
      r_write_ack <= '0;
      r_read_data <= '0;
      for (int a = 0; a < DEPTH; a++) r_mem[a] <= '0;
    end else begin
      if (w_any)
        r_rr_ptr <= (w_last == PW'(LANE_WIDTH - 1)) ? '0 : w_last + 1'b1;
      for (int i = 0; i < LANE_WIDTH; i++) begin
        // A lane with both valids high is a write; a served lane re-arms once both valids drop.
        r_ready_ack[i] <= w_grant[i] & ~bus.mem_write_valid[i];
        r_write_ack[i] <= w_grant[i] & bus.mem_write_valid[i];
        r_served[i]    <= w_grant[i] | (r_served[i] & w_active[i]);
        if (w_grant[i] && !bus.mem_write_valid[i])
          r_read_data[i] <= r_mem[bus.mem_addr[i]];
      end
      // Ascending lane order lets the highest lane win; the host write lands last and wins over all.
      for (int i = 0; i < LANE_WIDTH; i++) begin
        if (w_grant[i] && bus.mem_write_valid[i])
          r_mem[bus.mem_addr[i]] <= bus.mem_write_data[i];
      end
      if (host_write_en)
        r_mem[host_addr] <= host_data;
    end
  end

  assign bus.data_mem_ready_ack = r_ready_ack;
  assign bus.data_mem_write_ack = r_write_ack;
  assign bus.mem_read_data      = r_read_data;
  assign o_rr_ptr               = r_rr_ptr;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: single read, arbitration order, fairness,
// same-cycle conflicts, host priority and reset in the middle of traffic.
module tb_data_mem_responder;
  localparam int DW = 64;
  localparam int AW = 7;
  localparam int LW = 16;
  localparam int NP = 4;

  logic          clk;
  logic          rst;
  logic          host_write_en;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic [3:0]    rr_ptr;

  int checks = 0;
  int errors = 0;

  data_mem_responder_if #(.DATA_WIDTH(DW), .DATA_REG_ADDR_WIDTH(AW), .LANE_WIDTH(LW)) bus ();

  data_mem_responder #(
    .DATA_WIDTH(DW), .DATA_REG_ADDR_WIDTH(AW), .LANE_WIDTH(LW), .NUM_PORTS(NP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .host_write_en (host_write_en),
    .host_addr     (host_addr),
    .host_data     (host_data),
    .o_rr_ptr      (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_lanes();
    bus.mem_read_valid  = '0;
    bus.mem_write_valid = '0;
    bus.mem_addr        = '0;
    bus.mem_write_data  = '0;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_write_en = 1'b1;
    host_addr     = a;
    host_data     = d;
    tick();
    host_write_en = 1'b0;
  endtask

  initial begin
    int lat;
    bit got;
    rst = 1'b1;
    host_write_en = 1'b0;
    host_addr = '0;
    host_data = '0;
    clear_lanes();
    tick();
    tick();
    rst = 1'b0;
    check("reset_ready_ack", 64'(bus.data_mem_ready_ack), 64'h0);
    check("reset_write_ack", 64'(bus.data_mem_write_ack), 64'h0);
    check("reset_rdata3", bus.mem_read_data[3], 64'h0);
    check("reset_rr_ptr", 64'(rr_ptr), 64'h0);

    // 1. single read of a preloaded word, valid held three cycles
    host_wr(7'd5, 64'hDEAD);
    bus.mem_read_valid[3] = 1'b1;
    bus.mem_addr[3]       = 7'd5;
    tick();
    check("t1_ack_first", 64'(bus.data_mem_ready_ack), 64'h0008);
    check("t1_wack_none", 64'(bus.data_mem_write_ack), 64'h0);
    check("t1_rdata", bus.mem_read_data[3], 64'hDEAD);
    check("t1_rr_ptr", 64'(rr_ptr), 64'd4);
    tick();
    check("t1_ack_second", 64'(bus.data_mem_ready_ack), 64'h0);
    tick();
    check("t1_ack_third", 64'(bus.data_mem_ready_ack), 64'h0);
    check("t1_rdata_hold", bus.mem_read_data[3], 64'hDEAD);
    clear_lanes();
    tick();

    // 2. all lanes read at once after a fresh reset and preload
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < LW; i++) host_wr(AW'(i), 64'h100 + 64'(i));
    for (int i = 0; i < LW; i++) begin
      bus.mem_read_valid[i] = 1'b1;
      bus.mem_addr[i]       = AW'(i);
    end
    tick();
    check("t2_ack_0_3", 64'(bus.data_mem_ready_ack), 64'h000F);
    tick();
    check("t2_ack_4_7", 64'(bus.data_mem_ready_ack), 64'h00F0);
    tick();
    check("t2_ack_8_11", 64'(bus.data_mem_ready_ack), 64'h0F00);
    tick();
    check("t2_ack_12_15", 64'(bus.data_mem_ready_ack), 64'hF000);
    check("t2_rr_ptr", 64'(rr_ptr), 64'h0);
    tick();
    check("t2_ack_done", 64'(bus.data_mem_ready_ack), 64'h0);
    for (int i = 0; i < LW; i++)
      check($sformatf("t2_rdata%0d", i), bus.mem_read_data[i], 64'h100 + 64'(i));
    clear_lanes();
    tick();

    // 3. lanes 0-7 keep re-requesting; lane 15 asks once
    for (int i = 0; i < 8; i++) bus.mem_read_valid[i] = 1'b1;
    bus.mem_read_valid[15] = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      tick();
      for (int i = 0; i < 8; i++) bus.mem_read_valid[i] = ~bus.data_mem_ready_ack[i];
      if (bus.data_mem_ready_ack[15]) begin
        got = 1'b1;
        lat = c;
        bus.mem_read_valid[15] = 1'b0;
      end
    end
    check("t3_lane15_latency", 64'(lat), 64'd3);
    check("t3_rr_ptr", 64'(rr_ptr), 64'd3);
    clear_lanes();
    tick();
    tick();

    // 4. same-cycle conflicts: two writes and a read to addr 7, plus a read+write lane
    host_wr(7'd7, 64'h55);
    bus.mem_write_valid[2] = 1'b1; bus.mem_addr[2] = 7'd7; bus.mem_write_data[2] = 64'h11;
    bus.mem_write_valid[9] = 1'b1; bus.mem_addr[9] = 7'd7; bus.mem_write_data[9] = 64'h99;
    bus.mem_read_valid[4]  = 1'b1; bus.mem_addr[4] = 7'd7;
    bus.mem_read_valid[1]  = 1'b1; bus.mem_write_valid[1] = 1'b1;
    bus.mem_addr[1] = 7'd8; bus.mem_write_data[1] = 64'hAB;
    tick();
    check("t4_write_ack", 64'(bus.data_mem_write_ack), 64'h0206);
    check("t4_ready_ack", 64'(bus.data_mem_ready_ack), 64'h0010);
    check("t4_old_data", bus.mem_read_data[4], 64'h55);
    clear_lanes();
    tick();
    bus.mem_read_valid[0]  = 1'b1; bus.mem_addr[0] = 7'd7;
    bus.mem_read_valid[5]  = 1'b1; bus.mem_addr[5] = 7'd8;
    bus.mem_write_valid[6] = 1'b1; bus.mem_addr[6] = 7'd10; bus.mem_write_data[6] = 64'h66;
    host_write_en = 1'b1; host_addr = 7'd10; host_data = 64'hCC;
    tick();
    host_write_en = 1'b0;
    check("t4_ready_ack2", 64'(bus.data_mem_ready_ack), 64'h0021);
    check("t4_write_ack2", 64'(bus.data_mem_write_ack), 64'h0040);
    check("t4_high_lane_wins", bus.mem_read_data[0], 64'h99);
    check("t4_rw_is_write", bus.mem_read_data[5], 64'hAB);
    clear_lanes();
    tick();
    bus.mem_read_valid[7] = 1'b1; bus.mem_addr[7] = 7'd10;
    tick();
    check("t4_host_priority", bus.mem_read_data[7], 64'hCC);
    clear_lanes();
    tick();

    // 5. reset after the first grant of a full request burst
    check("t5_rr_ptr_pre", 64'(rr_ptr), 64'd8);
    for (int i = 0; i < LW; i++) begin
      bus.mem_read_valid[i] = 1'b1;
      bus.mem_addr[i]       = AW'(i);
    end
    tick();
    check("t5_first_grant", 64'(bus.data_mem_ready_ack), 64'h0F00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_no_ack_after_rst", 64'(bus.data_mem_ready_ack), 64'h0);
    check("t5_rr_ptr_reset", 64'(rr_ptr), 64'h0);
    tick();
    check("t5_regrant_from_0", 64'(bus.data_mem_ready_ack), 64'h000F);
    check("t5_array_cleared0", bus.mem_read_data[0], 64'h0);
    check("t5_array_cleared3", bus.mem_read_data[3], 64'h0);
    clear_lanes();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
